neuron_bit_serializer: RTL and testbench

- Upstream feeder for the serial inner-product array; one instance drives all Tw×Ti serial neuron lanes.
- Accepts one parallel brick of Tw×Ti two's-complement neurons over a valid/ready handshake.
- Streams the brick MSB-first, one bit per lane per cycle, for the brick's programmed precision.
- Generates the sign-bit flag, accumulator-load pulse and result-valid strobe that the serial inner-product tiles and the NBout writeback consume.

---
 rtl/neuron_bit_serializer.sv | 154 +++++++++++++++
 tb/tb_neuron_bit_serializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_bit_serializer.sv
// Parallel-to-serial neuron brick feeder: streams Tw*Ti lanes MSB-first at a per-brick precision.
// Optional staging buffer enabled by defining NBS_STAGING_BUF_EN.

module nbs_lane #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [N-1:0] din_i,
  input  logic [4:0]   shamt_i,
  output logic         bit_o
);
  logic [N-1:0] sreg_q, sreg_d;

  // P shifts empty the register, so the lane reads zero in DRAIN/IDLE for free
  always_comb begin
    sreg_d = sreg_q;
    if (load_i)       sreg_d = din_i << shamt_i;
    else if (shift_i) sreg_d = sreg_q << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) sreg_q <= '0;
    else       sreg_q <= sreg_d;
  end

  assign bit_o = sreg_q[N-1];
endmodule

module neuron_bit_serializer #(
  parameter int N  = 16,
  parameter int Ti = 16,
  parameter int Tw = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [4:0]          i_precision,
  input  logic [N*Ti*Tw-1:0]  i_neurons,
  output logic [Ti*Tw-1:0]    o_neurons,
  output logic                o_first_cycle,
  output logic                o_acc_reset,
  output logic                o_busy,
  output logic                o_result_valid
);
  localparam int NUM_LANES = Ti*Tw;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic          first_q, rv_q;

  logic [NUM_LANES-1:0][N-1:0] in_neur, src_neur;
  logic [4:0] src_p, shamt;
  logic       accept, load, can_load, shift;

  function automatic logic [4:0] eff_p(input logic [4:0] p);
    return (p == 5'd0 || p > 5'(N)) ? 5'(N) : p;
  endfunction

  assign in_neur = i_neurons;

`ifdef NBS_STAGING_BUF_EN
  logic [NUM_LANES-1:0][N-1:0] stg_neur_q;
  logic [4:0]                  stg_p_q;
  logic                        stg_full_q;

  assign can_load = (state_q == IDLE) || (state_q == DRAIN);
  assign o_ready  = !reset && (!stg_full_q || can_load);
  assign accept   = i_valid && o_ready;
  // An empty stage is bypassed so an idle block starts streaming next cycle
  assign load     = can_load && (stg_full_q || accept);
  assign src_neur = stg_full_q ? stg_neur_q : in_neur;
  assign src_p    = stg_full_q ? stg_p_q : eff_p(i_precision);

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_full_q <= 1'b0;
    end else if (accept && (stg_full_q || !can_load)) begin
      stg_full_q <= 1'b1;
      stg_neur_q <= in_neur;
      stg_p_q    <= eff_p(i_precision);
    end else if (load) begin
      stg_full_q <= 1'b0;
    end
  end
`else
  assign can_load = (state_q == IDLE);
  assign o_ready  = !reset && can_load;
  assign accept   = i_valid && o_ready;
  assign load     = accept;
  assign src_neur = in_neur;
  assign src_p    = eff_p(i_precision);
`endif

  assign shamt = 5'(N) - src_p;
  assign shift = (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      first_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      first_q <= 1'b0;
      rv_q    <= 1'b0;
      unique case (state_q)
        IDLE: if (load) begin
          state_q <= SHIFT;
          k_q     <= KW'(src_p - 5'd1);
          first_q <= 1'b1;
        end
        SHIFT: begin
          if (k_q == '0) state_q <= DRAIN;
          else           k_q     <= k_q - KW'(1);
        end
        DRAIN: begin
          rv_q <= 1'b1;
          if (load) begin
            state_q <= SHIFT;
            k_q     <= KW'(src_p - 5'd1);
            first_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    nbs_lane #(.N(N)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .shift_i (shift),
      .din_i   (src_neur[l]),
      .shamt_i (shamt),
      .bit_o   (o_neurons[l])
    );
  end

  assign o_first_cycle  = first_q;
  assign o_acc_reset    = first_q;
  assign o_result_valid = rv_q;
  assign o_busy         = (state_q != IDLE);
endmodule

// File: tb/tb_neuron_bit_serializer.sv
// Bench for neuron_bit_serializer: directed and random bricks vs a per-cycle expected trace.
module tb_neuron_bit_serializer;
  localparam int N = 16, TI = 16, TW = 16, L = TI*TW;
`ifdef NBS_STAGING_BUF_EN
  localparam bit STG = 1'b1;
`else
  localparam bit STG = 1'b0;
`endif

  logic           clk;
  logic           reset, i_valid, o_ready;
  logic [4:0]     i_precision;
  logic [N*L-1:0] i_neurons;
  logic [L-1:0]   o_neurons;
  logic           o_first_cycle, o_acc_reset, o_busy, o_result_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  neuron_bit_serializer #(.N(N), .Ti(TI), .Tw(TW)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_precision(i_precision), .i_neurons(i_neurons), .o_neurons(o_neurons),
    .o_first_cycle(o_first_cycle), .o_acc_reset(o_acc_reset),
    .o_busy(o_busy), .o_result_valid(o_result_valid)
  );

  int checks = 0, errors = 0, cyc = 0;
  int last_drain = -10;
  logic [L-1:0] e_bits [int];
  bit e_first [int];
  bit e_busy  [int];
  bit e_rv    [int];
  int acc_c[$];
  int start_c[$];

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [N*L-1:0] rand_brick();
    logic [N*L-1:0] r;
    for (int i = 0; i < N*L/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Brick of P bits starts at the later of acc+1 and the cycle after the previous DRAIN
  task automatic add_brick(input logic [N*L-1:0] nb, input logic [4:0] p, input int acc);
    int pe, s;
    logic [L-1:0] v;
    pe = (p == 5'd0 || p > 5'd16) ? 16 : int'(p);
    s = acc + 1;
    if (s <= last_drain) s = last_drain + 1;
    for (int j = 0; j < pe; j++) begin
      for (int l = 0; l < L; l++) v[l] = nb[l*N + pe - 1 - j];
      e_bits[s+j] = v;
      e_busy[s+j] = 1'b1;
    end
    e_first[s] = 1'b1;
    e_busy[s+pe] = 1'b1;
    e_rv[s+pe+1] = 1'b1;
    last_drain = s + pe;
    acc_c.push_back(acc);
    start_c.push_back(s);
  endtask

  task automatic check_outputs();
    logic [L-1:0] eb;
    bit ef, eu, er;
    eb = e_bits.exists(cyc) ? e_bits[cyc] : '0;
    ef = e_first.exists(cyc) ? e_first[cyc] : 1'b0;
    eu = e_busy.exists(cyc) ? e_busy[cyc] : 1'b0;
    er = e_rv.exists(cyc) ? e_rv[cyc] : 1'b0;
    checks++;
    assert (o_neurons === eb) else begin errors++; $error("FAIL neurons cyc=%0d got=%h exp=%h", cyc, o_neurons, eb); end
    checks++;
    assert (o_first_cycle === ef) else begin errors++; $error("FAIL first_cycle cyc=%0d got=%b exp=%b", cyc, o_first_cycle, ef); end
    checks++;
    assert (o_acc_reset === ef) else begin errors++; $error("FAIL acc_reset cyc=%0d got=%b exp=%b", cyc, o_acc_reset, ef); end
    checks++;
    assert (o_busy === eu) else begin errors++; $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, eu); end
    checks++;
    assert (o_result_valid === er) else begin errors++; $error("FAIL result_valid cyc=%0d got=%b exp=%b", cyc, o_result_valid, er); end
  endtask

  task automatic drive_cycle(input bit rst, input bit v, input logic [N*L-1:0] nb,
                             input logic [4:0] p, output bit acc);
    bit exp_rdy;
    check_outputs();
    reset = rst; i_valid = v; i_neurons = nb; i_precision = p;
    #1;
    if (rst) exp_rdy = 1'b0;
    else if (STG) begin
      // ready unless a brick accepted earlier still waits past this cycle
      exp_rdy = 1'b1;
      foreach (acc_c[b]) if (acc_c[b] < cyc && start_c[b] > cyc + 1) exp_rdy = 1'b0;
    end else exp_rdy = !(e_busy.exists(cyc) && e_busy[cyc]);
    checks++;
    assert (o_ready === exp_rdy) else begin errors++; $error("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_ready, exp_rdy); end
    acc = v && o_ready;
    if (acc) add_brick(nb, p, cyc);
    if (rst) begin
      e_bits.delete(); e_first.delete(); e_busy.delete(); e_rv.delete();
      acc_c.delete(); start_c.delete();
      last_drain = -10;
    end
    tick();
  endtask

  task automatic offer(input logic [N*L-1:0] nb, input logic [4:0] p);
    bit a;
    int n;
    a = 1'b0; n = 0;
    while (!a && n < 100) begin
      drive_cycle(1'b0, 1'b1, nb, p, a);
      n++;
    end
    checks++;
    assert (a) else begin errors++; $error("FAIL accept_timeout cyc=%0d got=0 exp=1", cyc); end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, rand_brick(), 5'($urandom_range(0, 31)), a);
  endtask

  initial begin
    bit a, got;
    logic [N*L-1:0] nb, nb2;
    int b0, sa;
    reset = 1'b1; i_valid = 1'b0; i_precision = '0; i_neurons = '0;
    tick();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, rand_brick(), 5'd5, a);

    // P=16, lane 0 = 8001
    nb = '0; nb[15:0] = 16'h8001;
    offer(nb, 5'd16);
    idle(20);

    // P=4, lane (3,5) with garbage above bit 3
    nb = '0; nb[(3*16+5)*N +: N] = 16'hFFFB;
    offer(nb, 5'd4);
    idle(8);

    // Out-of-range precision codes behave as 16
    offer(rand_brick(), 5'd0);
    idle(19);
    offer(rand_brick(), 5'd20);
    idle(19);

    // Three P=3 bricks back to back
    b0 = start_c.size();
    offer(rand_brick(), 5'd3);
    offer(rand_brick(), 5'd3);
    offer(rand_brick(), 5'd3);
    idle(8);
    checks++;
    assert (start_c[b0+1] - start_c[b0] == (STG ? 4 : 5)) else begin
      errors++; $error("FAIL spacing01 got=%0d exp=%0d", start_c[b0+1] - start_c[b0], STG ? 4 : 5); end
    checks++;
    assert (start_c[b0+2] - start_c[b0+1] == (STG ? 4 : 5)) else begin
      errors++; $error("FAIL spacing12 got=%0d exp=%0d", start_c[b0+2] - start_c[b0+1], STG ? 4 : 5); end

    // P=1, value 1
    nb = '0; nb[15:0] = 16'h0001;
    offer(nb, 5'd1);
    idle(5);

    // Reset during the 3rd SHIFT cycle of a P=8 brick with another pending
    offer(rand_brick(), 5'd8);
    sa = start_c[start_c.size()-1];
    nb2 = rand_brick();
    got = 1'b0;
    while (cyc < sa + 2) begin
      drive_cycle(1'b0, !got, nb2, 5'd8, a);
      if (a) got = 1'b1;
    end
    drive_cycle(1'b1, 1'b0, nb2, 5'd8, a);
    idle(30);

    // Random bricks with random gaps
    for (int i = 0; i < 25; i++) begin
      idle($urandom_range(0, 3));
      offer(rand_brick(), 5'($urandom_range(0, 31)));
    end
    idle(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
